car_detector: RTL and testbench
===============================

CAR_DETECTOR -- requirements
Module: car_detector

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, consecutive equal samples needed before a filtered sensor changes; used only when CAR_DETECT_DEBOUNCE_EN is defined.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 a  input  1  outer photo-sensor; 1 = beam blocked.
REQ-005 b  input  1  inner photo-sensor; 1 = beam blocked.
REQ-006 enter  output  1  one-cycle pulse, one complete entry; drives the occupancy counter's count input.
REQ-007 exit  output  1  one-cycle pulse, one complete exit.
REQ-008 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-009 fault  output  1  one-cycle pulse on entry to WAIT.

Function
REQ-010 The FSM SHALL sample the pair {a,b} on every rising edge; a sample is written as ab, e.g. 10 = a blocked, b clear.
REQ-011 The FSM SHALL have exactly eight states: IDLE, E1, E2, E3, X1, X2, X3 and WAIT.
REQ-012 From IDLE, the FSM SHALL go to E1 on 10, go to X1 on 01, stay in IDLE on 00, and go to WAIT on 11.
REQ-013 The entry path SHALL be: E1 (10→E2 on 11, 00→IDLE), E2 (11 stays, 10→E1, 01→E3), E3 (01 stays, 11→E2, 00→IDLE with enter pulse).
REQ-014 The exit path SHALL be the mirror image: X1 on 01, X2 on 11, X3 on 10; X3 on 00 SHALL go to IDLE with an exit pulse.
REQ-015 In E1, E2, E3, X1, X2 and X3, a state SHALL stay put while its own pattern repeats.
REQ-016 Any sample not listed for the current state (e.g. E1 sees 01, E3 sees 10) SHALL move the FSM to WAIT and pulse fault.
REQ-017 WAIT SHALL hold until a 00 sample, then return to IDLE with no pulse.
REQ-018 enter, exit and fault SHALL be registered outputs that are high for exactly one clk cycle, in the cycle after the qualifying edge.
REQ-019 enter and exit SHALL never be high in the same cycle.
REQ-020 busy SHALL be registered and SHALL reflect the state after the current edge.
REQ-021 A backed-out car (E1→IDLE, or X1→IDLE via 00) SHALL produce no pulse.
REQ-022 Sustained 00 SHALL keep the FSM in IDLE indefinitely with every output low.

Reset
REQ-023 While reset is high at a rising edge, the block SHALL set the state to IDLE and drive enter=0, exit=0, busy=0 and fault=0.
REQ-024 While reset is high, the block SHALL clear all synchronizer, filter and counter registers to 0.
REQ-025 Reset SHALL take priority over every sensor input.
REQ-026 Reset during a partial sequence SHALL abandon that sequence with no pulse.
REQ-027 After reset deasserts, the FSM SHALL evaluate the next sample from IDLE according to REQ-012.

Configuration
REQ-028 When CAR_DETECT_DEBOUNCE_EN is defined, each sensor SHALL pass through a 2-flop synchronizer and then a filter.
REQ-029 That filter SHALL change its output only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-030 That filter's counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL restart on any differing sample.
REQ-031 With the macro defined, the FSM SHALL consume the filtered values, adding 2+DEBOUNCE_CYCLES cycles of input-to-state latency.
REQ-032 When the macro is not defined, a and b SHALL feed the FSM directly, and no synchronizer or filter logic SHALL be present.

Verification (macro undefined unless stated)
REQ-033 Sequence 00,10,11,01,00 one cycle each after reset → enter=1 for exactly one cycle after the final 00 edge; exit=0 and fault=0 throughout.
REQ-034 Sequence 00,01,11,10,00 → exit pulses once; busy=1 from the 01 edge through the final 00 edge, then 0.
REQ-035 Sequence 10,11,10,00 (car backs out) → no enter, no exit, no fault; FSM ends in IDLE.
REQ-036 Sequence 10,01,01,00 → fault pulses once after the 01 edge; busy stays 1 until 00; no enter or exit.
REQ-037 Sequence 10,11 then reset=1 for 2 cycles, then 00 → all outputs 0 during and after reset; no enter pulse.
REQ-038 With macro defined and DEBOUNCE_CYCLES=4, a 3-cycle glitch of a=1 → no state change and busy stays 0; a full entry with each pattern held 6 cycles → exactly one enter pulse.

Source files
------------

// File: rtl/car_detector.sv
// Two-sensor car entry/exit detector: an eight-state FSM emits enter/exit/fault pulses.
// Define CAR_DETECT_DEBOUNCE_EN to add a synchronizer and debounce filter on each sensor.
`ifdef CAR_DETECT_DEBOUNCE_EN
module car_detector_filter #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive synchronized samples that disagree with filt.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule
`endif

module car_detector #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter,
  output logic exit,
  output logic busy,
  output logic fault
);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    E1   = 3'd1,
    E2   = 3'd2,
    E3   = 3'd3,
    X1   = 3'd4,
    X2   = 3'd5,
    X3   = 3'd6,
    WAIT = 3'd7
  } state_t;

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("car_detector: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [1:0] ab;

`ifdef CAR_DETECT_DEBOUNCE_EN
  logic [1:0] raw;
  assign raw = {a, b};

  for (genvar i = 0; i < 2; i++) begin : g_filt
    car_detector_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[i]),
      .filt  (ab[i])
    );
  end
`else
  assign ab = {a, b};
`endif

  state_t state, state_nxt;
  logic   enter_nxt, exit_nxt, fault_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      enter <= 1'b0;
      exit  <= 1'b0;
      busy  <= 1'b0;
      fault <= 1'b0;
    end else begin
      state <= state_nxt;
      enter <= enter_nxt;
      exit  <= exit_nxt;
      busy  <= (state_nxt != IDLE);
      fault <= fault_nxt;
    end
  end

  // Pulses are decided from the transition taken on this edge, so they
  // appear registered in the following cycle.
  always_comb begin
    state_nxt = state;
    enter_nxt = 1'b0;
    exit_nxt  = 1'b0;
    fault_nxt = 1'b0;
    unique case (state)
      IDLE: case (ab)
        2'b10:   state_nxt = E1;
        2'b01:   state_nxt = X1;
        2'b11:   state_nxt = WAIT;
        default: state_nxt = IDLE;
      endcase
      E1: case (ab)
        2'b10:   state_nxt = E1;
        2'b11:   state_nxt = E2;
        2'b00:   state_nxt = IDLE;
        default: state_nxt = WAIT;
      endcase
      E2: case (ab)
        2'b11:   state_nxt = E2;
        2'b10:   state_nxt = E1;
        2'b01:   state_nxt = E3;
        default: state_nxt = WAIT;
      endcase
      E3: case (ab)
        2'b01:   state_nxt = E3;
        2'b11:   state_nxt = E2;
        2'b00: begin
          state_nxt = IDLE;
          enter_nxt = 1'b1;
        end
        default: state_nxt = WAIT;
      endcase
      X1: case (ab)
        2'b01:   state_nxt = X1;
        2'b11:   state_nxt = X2;
        2'b00:   state_nxt = IDLE;
        default: state_nxt = WAIT;
      endcase
      X2: case (ab)
        2'b11:   state_nxt = X2;
        2'b01:   state_nxt = X1;
        2'b10:   state_nxt = X3;
        default: state_nxt = WAIT;
      endcase
      X3: case (ab)
        2'b10:   state_nxt = X3;
        2'b11:   state_nxt = X2;
        2'b00: begin
          state_nxt = IDLE;
          exit_nxt  = 1'b1;
        end
        default: state_nxt = WAIT;
      endcase
      WAIT: state_nxt = (ab == 2'b00) ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == WAIT && state != WAIT) fault_nxt = 1'b1;
  end
endmodule

// File: tb/tb_car_detector.sv
// Directed bench for car_detector; outputs packed as {enter,exit,busy,fault}.
`timescale 1ns/1ps
module tb_car_detector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0;
  logic b = 1'b0;
  logic enter, exit, busy, fault;
  int   tests = 0;
  int   errors = 0;

  car_detector #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .enter (enter),
    .exit  (exit),
    .busy  (busy),
    .fault (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] obs();
    return {enter, exit, busy, fault};
  endfunction

  // Drive inputs, take one rising edge, then settle away from the edge.
  task automatic step(input logic va, input logic vb, input logic vr);
    a = va;
    b = vb;
    reset = vr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1);
      tests++;
      if (obs() !== 4'b0000) begin
        errors++;
        $display("FAIL reset cycle %0d: got %b expected 0000", i, obs());
      end
    end
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (obs() !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b expected 0000", obs());
    end
  endtask

`ifndef CAR_DETECT_DEBOUNCE_EN
  task automatic test_entry();
    logic [1:0] ab [7] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00};
    logic [3:0] ex [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0000, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      step(ab[i][1], ab[i][0], 1'b0);
      tests++;
      if (obs() !== ex[i]) begin
        errors++;
        $display("FAIL entry step %0d: got %b expected %b", i, obs(), ex[i]);
      end
    end
  endtask

  task automatic test_exit();
    logic [1:0] ab [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [3:0] ex [6] = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0100, 4'b0000};
    for (int i = 0; i < 6; i++) begin
      step(ab[i][1], ab[i][0], 1'b0);
      tests++;
      if (obs() !== ex[i]) begin
        errors++;
        $display("FAIL exit step %0d: got %b expected %b", i, obs(), ex[i]);
      end
    end
  endtask

  task automatic test_backout();
    logic [1:0] ab [7] = '{2'b10, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};
    logic [3:0] ex [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      step(ab[i][1], ab[i][0], 1'b0);
      tests++;
      if (obs() !== ex[i]) begin
        errors++;
        $display("FAIL backout step %0d: got %b expected %b", i, obs(), ex[i]);
      end
    end
  endtask

  task automatic test_fault();
    // E1 sees 01; IDLE sees 11; E3 sees 10.
    logic [1:0] ab [13] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b11, 2'b11, 2'b00,
                            2'b10, 2'b11, 2'b01, 2'b10, 2'b10, 2'b00};
    logic [3:0] ex [13] = '{4'b0010, 4'b0011, 4'b0010, 4'b0000, 4'b0011, 4'b0010, 4'b0000,
                            4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0010, 4'b0000};
    for (int i = 0; i < 13; i++) begin
      step(ab[i][1], ab[i][0], 1'b0);
      tests++;
      if (obs() !== ex[i]) begin
        errors++;
        $display("FAIL fault step %0d: got %b expected %b", i, obs(), ex[i]);
      end
    end
  endtask

  task automatic test_hold_and_retreat();
    // Repeated patterns hold; E2->E1 and X2->X1 retreats; X3->X2 retreat.
    logic [1:0] ab [16] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b01, 2'b01, 2'b00,
                            2'b01, 2'b11, 2'b01, 2'b11, 2'b10, 2'b11, 2'b10};
    logic [3:0] ex [16] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                            4'b0010, 4'b1000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
                            4'b0010, 4'b0010};
    for (int i = 0; i < 16; i++) begin
      step(ab[i][1], ab[i][0], 1'b0);
      tests++;
      if (obs() !== ex[i]) begin
        errors++;
        $display("FAIL hold step %0d: got %b expected %b", i, obs(), ex[i]);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    tests++;
    if (obs() !== 4'b0100) begin
      errors++;
      $display("FAIL hold_exit: got %b expected 0100", obs());
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ab [9] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [3:0] ex [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010, 4'b0010,
                           4'b0100, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      step(ab[i][1], ab[i][0], 1'b0);
      tests++;
      if (obs() !== ex[i]) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b expected %b", i, obs(), ex[i]);
      end
    end
  endtask

  task automatic test_reset_midseq();
    logic [1:0] ab [7] = '{2'b10, 2'b11, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00};
    logic       rs [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0] ex [7] = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
    for (int i = 0; i < 7; i++) begin
      step(ab[i][1], ab[i][0], rs[i]);
      tests++;
      if (obs() !== ex[i]) begin
        errors++;
        $display("FAIL reset_midseq step %0d: got %b expected %b", i, obs(), ex[i]);
      end
    end
  endtask

  task automatic test_idle_hold();
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (obs() !== 4'b0000) bad++;
    end
    tests++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold: got %0d non-zero cycles expected 0", bad);
    end
  endtask
`else
  task automatic test_debounce();
    int saw_busy = 0;
    int n_enter = 0;
    int n_exit = 0;
    int n_fault = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (busy) saw_busy++;
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (busy) saw_busy++;
    end
    tests++;
    if (saw_busy != 0) begin
      errors++;
      $display("FAIL debounce_glitch: got busy for %0d cycles expected 0", saw_busy);
    end
    saw_busy = 0;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < ((p == 3) ? 14 : 6); i++) begin
        case (p)
          0: step(1'b1, 1'b0, 1'b0);
          1: step(1'b1, 1'b1, 1'b0);
          2: step(1'b0, 1'b1, 1'b0);
          default: step(1'b0, 1'b0, 1'b0);
        endcase
        if (busy) saw_busy++;
        if (enter) n_enter++;
        if (exit) n_exit++;
        if (fault) n_fault++;
      end
    end
    tests++;
    if (n_enter != 1) begin
      errors++;
      $display("FAIL debounce_enter: got %0d enter cycles expected 1", n_enter);
    end
    tests++;
    if (n_exit != 0 || n_fault != 0) begin
      errors++;
      $display("FAIL debounce_clean: got exit=%0d fault=%0d expected 0/0", n_exit, n_fault);
    end
    tests++;
    if (saw_busy == 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL debounce_busy: got busy cycles %0d final %b expected >0 and 0", saw_busy, busy);
    end
  endtask
`endif

  initial begin
    #1;
    test_reset();
`ifndef CAR_DETECT_DEBOUNCE_EN
    test_entry();
    test_exit();
    test_backout();
    test_fault();
    test_hold_and_retreat();
    step(1'b0, 1'b0, 1'b0);
    test_back_to_back();
    test_reset_midseq();
    test_idle_hold();
`else
    test_debounce();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
